// File: rtl/snn_pkg.sv
// Shared definitions for the spiking front-end stages.
// Contents: encoder state enum, LFSR width/taps/default seed and the
// one-step LFSR update function used by lfsr16 (and by any later
// stochastic stage that needs the same sequence).
package snn_pkg;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } enc_state_t;

    localparam int unsigned LFSR_W = 16;

    // Fibonacci taps for x^16 + x^14 + x^13 + x^11 + 1 (bit positions 15, 13, 12, 10).
    localparam int unsigned LFSR_TAP_A = 15;
    localparam int unsigned LFSR_TAP_B = 13;
    localparam int unsigned LFSR_TAP_C = 12;
    localparam int unsigned LFSR_TAP_D = 10;

    localparam logic [LFSR_W-1:0] LFSR_DEFAULT_SEED = 16'hACE1;

    function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] cur);
        return {cur[LFSR_W-2:0],
                cur[LFSR_TAP_A] ^ cur[LFSR_TAP_B] ^ cur[LFSR_TAP_C] ^ cur[LFSR_TAP_D]};
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances only when asked.
// Ports:
//   clk   in   system clock, rising edge
//   rst   in   synchronous active-high reset, loads the seed
//   step  in   advance one position on this edge
//   state out  current LFSR contents (never zero)
// A zero SEED would lock the register at zero, so it is replaced by 1.
module lfsr16
    import snn_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = LFSR_DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              step,
    output logic [LFSR_W-1:0] state
);

    localparam logic [LFSR_W-1:0] INIT = (SEED == '0) ? LFSR_W'(1) : SEED;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
        end else if (step) begin
            state <= lfsr_next(state);
        end
    end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-codes one intensity sample into WINDOW stochastic spike bits.
// Each bit is 1 with probability intensity / 2^DATA_W, decided by comparing
// the low DATA_W bits of a free-running LFSR against the latched sample.
// Ports:
//   clk, rst     clock and synchronous active-high reset
//   pix_valid    sample available
//   pix_ready    encoder idle and able to accept (combinational from state)
//   pix_data     unsigned intensity
//   out_bit      spike bit for the neuron stage
//   out_valid    out_bit belongs to the current window
//   busy         encoder is not idle (combinational from state)
//   done         one-cycle pulse after the last bit of a window
//   spike_count  number of ones in the last completed window
module spike_rate_encoder
    import snn_pkg::*;
#(
    parameter int unsigned       DATA_W    = 8,
    parameter int unsigned       WINDOW    = 16,
    parameter logic [LFSR_W-1:0] LFSR_SEED = LFSR_DEFAULT_SEED
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         pix_valid,
    output logic                         pix_ready,
    input  logic [DATA_W-1:0]            pix_data,
    output logic                         out_bit,
    output logic                         out_valid,
    output logic                         busy,
    output logic                         done,
    output logic [$clog2(WINDOW+1)-1:0]  spike_count
);

    localparam int unsigned       CNT_W    = $clog2(WINDOW + 1);
    localparam logic [CNT_W-1:0]  WIN_END  = CNT_W'(WINDOW);
    localparam logic [DATA_W-1:0] INT_MAX  = '1;
    // Selects the low DATA_W bits of the LFSR as the random operand.
    localparam logic [LFSR_W-1:0] RND_MASK = LFSR_W'((32'd1 << DATA_W) - 32'd1);

    enc_state_t        state;
    logic [DATA_W-1:0] intensity;
    logic [CNT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  run_count;
    logic [LFSR_W-1:0] lfsr;

    logic              accept;
    logic              emit;
    logic              lfsr_step;
    logic [DATA_W-1:0] cur_int;
    logic              next_bit;

    assign pix_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign accept    = pix_valid && pix_ready;
    assign emit      = (state == RUN) && (bit_idx < WIN_END);
    assign lfsr_step = accept || emit;

    // Bit 0 is decided from the incoming sample on the accept edge itself.
    assign cur_int  = accept ? pix_data : intensity;
    assign next_bit = (cur_int == INT_MAX) || ((lfsr & RND_MASK) < LFSR_W'(cur_int));

    lfsr16 #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .step  (lfsr_step),
        .state (lfsr)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            intensity   <= '0;
            bit_idx     <= '0;
            run_count   <= '0;
            spike_count <= '0;
            out_bit     <= 1'b0;
            out_valid   <= 1'b0;
            done        <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        state     <= RUN;
                        intensity <= pix_data;
                        out_bit   <= next_bit;
                        out_valid <= 1'b1;
                        bit_idx   <= CNT_W'(1);
                        run_count <= CNT_W'(next_bit);
                    end
                end
                RUN: begin
                    if (emit) begin
                        out_bit   <= next_bit;
                        bit_idx   <= bit_idx + CNT_W'(1);
                        run_count <= run_count + CNT_W'(next_bit);
                    end else begin
                        // All WINDOW bits have been shown; close the window.
                        state       <= DONE;
                        out_bit     <= 1'b0;
                        out_valid   <= 1'b0;
                        done        <= 1'b1;
                        spike_count <= run_count;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder: default build (DATA_W=8, WINDOW=16,
// seed ACE1) plus a small build (DATA_W=4, WINDOW=2, seed 0).
module tb_spike_rate_encoder;

    logic       clk = 1'b0;
    logic       rst;
    logic       pix_valid;
    logic       pix_ready;
    logic [7:0] pix_data;
    logic       out_bit;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [4:0] spike_count;

    logic       pv2;
    logic       pr2;
    logic [3:0] pd2;
    logic       ob2;
    logic       ov2;
    logic       busy2;
    logic       done2;
    logic [1:0] sc2;

    int total = 0;
    int bad   = 0;

    logic [15:0] m_lfsr;
    logic [15:0] m2;
    int          m_cnt;

    always #5 clk = ~clk;

    spike_rate_encoder dut (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .out_bit     (out_bit),
        .out_valid   (out_valid),
        .busy        (busy),
        .done        (done),
        .spike_count (spike_count)
    );

    spike_rate_encoder #(
        .DATA_W    (4),
        .WINDOW    (2),
        .LFSR_SEED (16'h0000)
    ) dut2 (
        .clk         (clk),
        .rst         (rst),
        .pix_valid   (pv2),
        .pix_ready   (pr2),
        .pix_data    (pd2),
        .out_bit     (ob2),
        .out_valid   (ov2),
        .busy        (busy2),
        .done        (done2),
        .spike_count (sc2)
    );

    function automatic logic [15:0] m_step(input logic [15:0] x);
        return {x[14:0], x[15] ^ x[13] ^ x[12] ^ x[10]};
    endfunction

    function automatic logic m_bit8(input logic [7:0] d, input logic [15:0] l);
        if (d == 8'hFF) return 1'b1;
        return (l[7:0] < d);
    endfunction

    function automatic logic m_bit4(input logic [3:0] d, input logic [15:0] l);
        if (d == 4'hF) return 1'b1;
        return (l[3:0] < d);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_accept(input logic [7:0] d, input bit hold);
        pix_valid = 1'b1;
        pix_data  = d;
        chk("ready_before_accept", 32'(pix_ready), 32'd1);
        tick();
        if (!hold) pix_valid = 1'b0;
    endtask

    // Checks all bits of a window that has just been accepted, then done and return to idle.
    task automatic run_body(input logic [7:0] d, input bit hold);
        logic b;
        m_cnt = 0;
        for (int i = 0; i < 16; i++) begin
            b = m_bit8(d, m_lfsr);
            chk($sformatf("valid[%0d]", i), 32'(out_valid), 32'd1);
            chk($sformatf("bit[%0d] d=%0h", i, d), 32'(out_bit), 32'(b));
            chk("ready_in_run", 32'(pix_ready), 32'd0);
            chk("busy_in_run", 32'(busy), 32'd1);
            chk("no_done_in_run", 32'(done), 32'd0);
            m_cnt += int'(b);
            m_lfsr = m_step(m_lfsr);
            if (hold) pix_data = 8'(i * 37 + 5);
            tick();
        end
        chk("valid_after_window", 32'(out_valid), 32'd0);
        chk("bit_after_window", 32'(out_bit), 32'd0);
        chk("done_pulse", 32'(done), 32'd1);
        chk("count", 32'(spike_count), 32'(m_cnt));
        chk("ready_in_done", 32'(pix_ready), 32'd0);
        chk("busy_in_done", 32'(busy), 32'd1);
        tick();
        chk("done_drop", 32'(done), 32'd0);
        chk("ready_after_done", 32'(pix_ready), 32'd1);
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("count_held", 32'(spike_count), 32'(m_cnt));
    endtask

    initial begin
        rst       = 1'b1;
        pix_valid = 1'b0;
        pix_data  = 8'h00;
        pv2       = 1'b0;
        pd2       = 4'h0;
        m_lfsr    = 16'hACE1;
        m2        = 16'h0001;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_bit", 32'(out_bit), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(pix_ready), 32'd1);
        chk("rst_count", 32'(spike_count), 32'd0);

        // 1: intensity 0 never spikes
        do_accept(8'h00, 1'b0);
        run_body(8'h00, 1'b0);
        chk("s1_count_zero", 32'(spike_count), 32'd0);

        // 2: full scale always spikes
        do_accept(8'hFF, 1'b0);
        run_body(8'hFF, 1'b0);
        chk("s2_count_full", 32'(spike_count), 32'd16);

        // 3: mid intensities follow the LFSR; second window continues the sequence
        do_accept(8'h80, 1'b0);
        run_body(8'h80, 1'b0);
        do_accept(8'h40, 1'b0);
        run_body(8'h40, 1'b0);

        // 4: pix_valid held high, data changing; accepts every 18 cycles
        do_accept(8'hC0, 1'b1);
        run_body(8'hC0, 1'b1);
        do_accept(8'h20, 1'b1);
        run_body(8'h20, 1'b1);
        do_accept(8'h9A, 1'b1);
        run_body(8'h9A, 1'b1);
        pix_valid = 1'b0;

        // 5: reset at bit 7 discards the window and reloads the seed
        do_accept(8'h80, 1'b0);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("pre_rst_bit[%0d]", i), 32'(out_bit), 32'(m_bit8(8'h80, m_lfsr)));
            m_lfsr = m_step(m_lfsr);
            tick();
        end
        chk("pre_rst_valid", 32'(out_valid), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        m_lfsr = 16'hACE1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_count", 32'(spike_count), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_bit", 32'(out_bit), 32'd0);
        tick();
        chk("mid_rst_no_done", 32'(done), 32'd0);
        chk("mid_rst_ready", 32'(pix_ready), 32'd1);
        do_accept(8'h00, 1'b0);
        run_body(8'h00, 1'b0);
        do_accept(8'h80, 1'b0);
        run_body(8'h80, 1'b0);

        // 6: small build, zero seed becomes 1, 2-bit windows
        chk("d2_ready", 32'(pr2), 32'd1);
        chk("d2_count_rst", 32'(sc2), 32'd0);
        pv2 = 1'b1;
        pd2 = 4'hF;
        tick();
        pv2 = 1'b0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d2_valid_f[%0d]", i), 32'(ov2), 32'd1);
            chk($sformatf("d2_bit_f[%0d]", i), 32'(ob2), 32'(m_bit4(4'hF, m2)));
            m2 = m_step(m2);
            tick();
        end
        chk("d2_valid_end_f", 32'(ov2), 32'd0);
        chk("d2_done_f", 32'(done2), 32'd1);
        chk("d2_count_f", 32'(sc2), 32'd2);
        tick();
        chk("d2_ready_f", 32'(pr2), 32'd1);
        // From seed 1, rnd is 4 then 8: against 5 that gives bits 1,0.
        pv2 = 1'b1;
        pd2 = 4'h5;
        tick();
        pv2 = 1'b0;
        pd2 = 4'h0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("d2_bit_5[%0d]", i), 32'(ob2), 32'(m_bit4(4'h5, m2)));
            m2 = m_step(m2);
            tick();
        end
        chk("d2_done_5", 32'(done2), 32'd1);
        chk("d2_count_5", 32'(sc2), 32'd1);
        tick();
        chk("d2_idle_5", 32'(busy2), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Hard stop so a stuck run still reports.
    initial begin
        #200000;
        $display("FAIL timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
